zcu102_adc_clk_supervisor: RTL

ZCU102_ADC_CLK_SUPERVISOR -- requirements
Module: zcu102_adc_clk_supervisor

---
 rtl/zcu102_adc_clk_supervisor.sv | 133 +++++++++++++
 1 files changed

// File: rtl/zcu102_adc_clk_supervisor.sv
// ADC clock supervisor: lock filtering, reset sequencing, lock-loss counting and an
// optional ref_toggle frequency measurement (compiled in with ADC_CLK_SUP_FREQ_EN).
module zcu102_adc_clk_supervisor #(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 16,
  parameter int RST_HOLD    = 256,
  parameter int CNT_W       = 16
) (
  input  logic             adc_clk,
  input  logic             adc_rst_n,
  input  logic             mmcm_locked,
  input  logic             ref_toggle,
  input  logic             sw_rst,
  output logic             adc_rst,
  output logic             clk_ok,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             freq_valid
);

  localparam int MAXC = (LOCK_FILTER > RST_HOLD) ? LOCK_FILTER : RST_HOLD;
  localparam int FCW  = $clog2(MAXC + 1);

  typedef enum logic [1:0] {WAIT_LOCK, FILTER, HOLD, RUN} state_t;

  state_t                 state, state_nx;
  logic [FCW-1:0]         cnt, cnt_nx;
  logic                   loss;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   lock_s;

  assign lock_s = lock_sync[SYNC_STAGES-1];

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) lock_sync <= '0;
    else            lock_sync <= {lock_sync[SYNC_STAGES-2:0], mmcm_locked};
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    loss     = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nx = FILTER;
          cnt_nx   = FCW'(1);
        end
      end
      FILTER: begin
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
        end else if (cnt == FCW'(LOCK_FILTER)) begin
          state_nx = HOLD;
          cnt_nx   = FCW'(1);
        end else begin
          cnt_nx = cnt + FCW'(1);
        end
      end
      HOLD: begin
        if (!lock_s)                    state_nx = WAIT_LOCK;
        else if (cnt == FCW'(RST_HOLD)) state_nx = RUN;
        else                            cnt_nx   = cnt + FCW'(1);
      end
      RUN: begin
        if (!lock_s) begin
          state_nx = WAIT_LOCK;
          loss     = 1'b1;
        end
      end
      default: state_nx = WAIT_LOCK;
    endcase
    // A lock loss coinciding with sw_rst in RUN is still counted
    if (sw_rst) state_nx = WAIT_LOCK;
  end

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      adc_rst       <= 1'b1;
      clk_ok        <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      adc_rst <= (state_nx != RUN);
      clk_ok  <= (state_nx == RUN);
      if (loss && !(&lock_loss_cnt)) lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
    end
  end

`ifdef ADC_CLK_SUP_FREQ_EN
  logic [SYNC_STAGES-1:0] ref_sync;
  logic                   ref_s, ref_prev, ref_edge, seen_edge;
  logic [CNT_W-1:0]       win_cnt;

  assign ref_s    = ref_sync[SYNC_STAGES-1];
  assign ref_edge = ref_s ^ ref_prev;

  // First edge only opens the window; later edges report the closed window length
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      ref_sync   <= '0;
      ref_prev   <= 1'b0;
      seen_edge  <= 1'b0;
      win_cnt    <= '0;
      freq_cnt   <= '0;
      freq_valid <= 1'b0;
    end else begin
      ref_sync   <= {ref_sync[SYNC_STAGES-2:0], ref_toggle};
      ref_prev   <= ref_s;
      freq_valid <= 1'b0;
      if (ref_edge) begin
        win_cnt   <= CNT_W'(1);
        seen_edge <= 1'b1;
        if (seen_edge) begin
          freq_cnt   <= win_cnt;
          freq_valid <= 1'b1;
        end
      end else if (!(&win_cnt)) begin
        win_cnt <= win_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_ref;
  assign unused_ref = ref_toggle;
  assign freq_cnt   = '0;
  assign freq_valid = 1'b0;
`endif

endmodule
